data_path: RTL and testbench



---
 rtl/cpu_pkg.sv | 34 +++
 rtl/alu.sv | 31 +++
 rtl/data_path.sv | 129 ++++++++++++
 tb/tb_data_path.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit single-cycle processor: data widths,
// storage depths, ALU opcodes and operand-2 source encodings.
package cpu_pkg;

    localparam int unsigned DW   = 16;          // data / register width
    localparam int unsigned NREG = 8;           // register-file depth
    localparam int unsigned NMEM = 8;           // data-memory depth
    localparam int unsigned RAW  = 3;           // register index width
    localparam int unsigned MAW  = 3;           // memory address width
    localparam int unsigned OPW  = 4;           // opcode width
    localparam int unsigned IMMW = 6;           // signed immediate width
    localparam int unsigned SHW  = 3;           // shift-amount field width
    localparam int unsigned SAW  = $clog2(DW);  // usable shift-distance bits

    localparam logic [OPW-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0001;
    localparam logic [OPW-1:0] OP_AND  = 4'b0010;
    localparam logic [OPW-1:0] OP_OR   = 4'b0011;
    localparam logic [OPW-1:0] OP_XOR  = 4'b0100;
    localparam logic [OPW-1:0] OP_SLL  = 4'b0101;
    localparam logic [OPW-1:0] OP_ADDI = 4'b0110;
    localparam logic [OPW-1:0] OP_LW   = 4'b0111;
    localparam logic [OPW-1:0] OP_SW   = 4'b1000;
    localparam logic [OPW-1:0] OP_SRL  = 4'b1001;
    localparam logic [OPW-1:0] OP_SRA  = 4'b1010;
    localparam logic [OPW-1:0] OP_NOT  = 4'b1011;
    localparam logic [OPW-1:0] OP_SLT  = 4'b1100;

    localparam logic [1:0] SRC_REG   = 2'b00;
    localparam logic [1:0] SRC_IMM   = 2'b01;
    localparam logic [1:0] SRC_SHAMT = 2'b10;
    localparam logic [1:0] SRC_ZERO  = 2'b11;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU.
//   op_code  : operation select (OP_* in cpu_pkg)
//   in1, in2 : operands
//   result_c : result, modulo 2^DW, no flags; unknown opcodes yield 0
module alu
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] op_code,
    input  logic [DW-1:0]  in1,
    input  logic [DW-1:0]  in2,
    output logic [DW-1:0]  result_c
);

    always_comb begin
        result_c = '0;
        case (op_code)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: result_c = in1 + in2;
            OP_SUB: result_c = in1 - in2;
            OP_AND: result_c = in1 & in2;
            OP_OR:  result_c = in1 | in2;
            OP_XOR: result_c = in1 ^ in2;
            OP_SLL: result_c = in1 << in2[SAW-1:0];
            OP_SRL: result_c = in1 >> in2[SAW-1:0];
            OP_SRA: result_c = DW'($signed(in1) >>> in2[SAW-1:0]);
            OP_NOT: result_c = ~in1;
            OP_SLT: result_c = DW'($signed(in1) < $signed(in2));
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Execution half of the single-cycle CPU: 8x16 register file, ALU and
// 8x16 data memory. Decoded fields and strobes come from the control unit.
// Ports:
//   clk, reset (synchronous, active-low)
//   opCode, dst, src1, src2, shamt, iconst : decoded instruction fields
//   regWrite, memtoReg, memWrite, ALUsrc   : control strobes
//   reg0..reg7, dataMemValue0..7           : architectural state (debug)
//   ALUout, ALUin1, ALUin2, regDataIn      : internal buses (debug)
// Build option: define R0_ZERO_EN to hardwire register 0 to zero.
module data_path
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opCode,
    input  logic [RAW-1:0]  dst,
    input  logic [RAW-1:0]  src1,
    input  logic [RAW-1:0]  src2,
    input  logic [SHW-1:0]  shamt,
    input  logic [IMMW-1:0] iconst,
    input  logic            regWrite,
    input  logic            memtoReg,
    input  logic            memWrite,
    input  logic [1:0]      ALUsrc,
    output logic [DW-1:0]   reg0,
    output logic [DW-1:0]   reg1,
    output logic [DW-1:0]   reg2,
    output logic [DW-1:0]   reg3,
    output logic [DW-1:0]   reg4,
    output logic [DW-1:0]   reg5,
    output logic [DW-1:0]   reg6,
    output logic [DW-1:0]   reg7,
    output logic [DW-1:0]   dataMemValue0,
    output logic [DW-1:0]   dataMemValue1,
    output logic [DW-1:0]   dataMemValue2,
    output logic [DW-1:0]   dataMemValue3,
    output logic [DW-1:0]   dataMemValue4,
    output logic [DW-1:0]   dataMemValue5,
    output logic [DW-1:0]   dataMemValue6,
    output logic [DW-1:0]   dataMemValue7,
    output logic [DW-1:0]   ALUout,
    output logic [DW-1:0]   ALUin1,
    output logic [DW-1:0]   ALUin2,
    output logic [DW-1:0]   regDataIn
);

    logic [DW-1:0]  rf_q  [NREG];
    logic [DW-1:0]  rf_d  [NREG];
    logic [DW-1:0]  rf_rd [NREG];
    logic [DW-1:0]  mem_q [NMEM];
    logic [DW-1:0]  mem_d [NMEM];
    logic [MAW-1:0] mem_addr;

    // Architectural read view of the register file
    always_comb begin
        rf_rd = rf_q;
`ifdef R0_ZERO_EN
        rf_rd[0] = '0;
`endif
    end

    // Operand selection
    always_comb begin
        ALUin1 = rf_rd[src1];
        case (ALUsrc)
            SRC_REG:   ALUin2 = rf_rd[src2];
            SRC_IMM:   ALUin2 = {{(DW-IMMW){iconst[IMMW-1]}}, iconst};
            SRC_SHAMT: ALUin2 = DW'(shamt);
            SRC_ZERO:  ALUin2 = '0;
            default:   ALUin2 = '0;
        endcase
    end

    alu u_alu (
        .op_code  (opCode),
        .in1      (ALUin1),
        .in2      (ALUin2),
        .result_c (ALUout)
    );

    // Address wraps modulo the memory depth
    assign mem_addr  = ALUout[MAW-1:0];
    assign regDataIn = memtoReg ? mem_q[mem_addr] : ALUout;

    // Next state: both writes may commit in one cycle, each from pre-edge values
    always_comb begin
        rf_d  = rf_q;
        mem_d = mem_q;
        if (regWrite) begin
            rf_d[dst] = regDataIn;
        end
`ifdef R0_ZERO_EN
        rf_d[0] = '0;
`endif
        if (memWrite) begin
            mem_d[mem_addr] = rf_rd[dst];
        end
    end

    // State registers; reset wins over any concurrent write
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_q  <= '{default: '0};
            mem_q <= '{default: '0};
        end else begin
            rf_q  <= rf_d;
            mem_q <= mem_d;
        end
    end

    assign reg0 = rf_rd[0];
    assign reg1 = rf_rd[1];
    assign reg2 = rf_rd[2];
    assign reg3 = rf_rd[3];
    assign reg4 = rf_rd[4];
    assign reg5 = rf_rd[5];
    assign reg6 = rf_rd[6];
    assign reg7 = rf_rd[7];

    assign dataMemValue0 = mem_q[0];
    assign dataMemValue1 = mem_q[1];
    assign dataMemValue2 = mem_q[2];
    assign dataMemValue3 = mem_q[3];
    assign dataMemValue4 = mem_q[4];
    assign dataMemValue5 = mem_q[5];
    assign dataMemValue6 = mem_q[6];
    assign dataMemValue7 = mem_q[7];

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: expectations are queued as stimulus is
// applied and checked against the DUT when its outputs are valid.
module tb_data_path;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  opCode;
    logic [2:0]  dst, src1, src2, shamt;
    logic [5:0]  iconst;
    logic        regWrite, memtoReg, memWrite;
    logic [1:0]  ALUsrc;
    logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
    logic [15:0] dm0, dm1, dm2, dm3, dm4, dm5, dm6, dm7;
    logic [15:0] ALUout, ALUin1, ALUin2, regDataIn;

    data_path dut (
        .clk(clk), .reset(reset), .opCode(opCode), .dst(dst), .src1(src1),
        .src2(src2), .shamt(shamt), .iconst(iconst), .regWrite(regWrite),
        .memtoReg(memtoReg), .memWrite(memWrite), .ALUsrc(ALUsrc),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
        .dataMemValue0(dm0), .dataMemValue1(dm1), .dataMemValue2(dm2),
        .dataMemValue3(dm3), .dataMemValue4(dm4), .dataMemValue5(dm5),
        .dataMemValue6(dm6), .dataMemValue7(dm7),
        .ALUout(ALUout), .ALUin1(ALUin1), .ALUin2(ALUin2), .regDataIn(regDataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_MEM  = 8;
    localparam int S_ALU  = 16;
    localparam int S_IN1  = 17;
    localparam int S_IN2  = 18;
    localparam int S_WB   = 19;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mr[8];
    logic [15:0] mm[8];

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] obs(input int sel);
        case (sel)
            0: return reg0;  1: return reg1;  2: return reg2;  3: return reg3;
            4: return reg4;  5: return reg5;  6: return reg6;  7: return reg7;
            8: return dm0;   9: return dm1;   10: return dm2;  11: return dm3;
            12: return dm4;  13: return dm5;  14: return dm6;  15: return dm7;
            S_ALU: return ALUout;
            S_IN1: return ALUin1;
            S_IN2: return ALUin2;
            S_WB:  return regDataIn;
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic flush();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, obs(e.sel), e.val);
        end
    endtask

    // Reference model
    function automatic logic [15:0] m_rd(input logic [2:0] i);
`ifdef R0_ZERO_EN
        if (i == 3'd0) return 16'h0000;
`endif
        return mr[i];
    endfunction

    function automatic logic [15:0] m_in2();
        case (ALUsrc)
            2'b00:   return m_rd(src2);
            2'b01:   return iconst[5] ? {10'h3FF, iconst} : {10'h000, iconst};
            2'b10:   return {13'd0, shamt};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            4'd0, 4'd6, 4'd7, 4'd8: r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[3:0];
            4'd9:  r = a >> b[3:0];
            4'd10: begin
                r = a;
                for (int k = 0; k < int'(b[3:0]); k++) r = {r[15], r[15:1]};
            end
            4'd11: r = ~a;
            4'd12: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] m_alu();
        return ref_alu(opCode, m_rd(src1), m_in2());
    endfunction

    function automatic logic [15:0] m_wb();
        logic [15:0] a;
        a = m_alu();
        return memtoReg ? mm[a[2:0]] : a;
    endfunction

    // Advance one clock, updating the model from pre-edge values
    task automatic cycle();
        logic [15:0] a, wb, sd;
        a  = m_alu();
        wb = m_wb();
        sd = m_rd(dst);
        @(posedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                mr[i] = 16'h0000;
                mm[i] = 16'h0000;
            end
        end else begin
            if (regWrite) mr[dst] = wb;
            if (memWrite) mm[a[2:0]] = sd;
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] sh, input logic [5:0] ic,
                         input logic [1:0] asrc, input logic rw, input logic mtr, input logic mw);
        opCode = op; dst = d; src1 = s1; src2 = s2; shamt = sh; iconst = ic;
        ALUsrc = asrc; regWrite = rw; memtoReg = mtr; memWrite = mw;
        #1;
    endtask

    task automatic push_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            push($sformatf("%s_reg%0d", tag, i), i, 16'h0000);
            push($sformatf("%s_mem%0d", tag, i), S_MEM + i, 16'h0000);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(OP_ADD, 3'd0, 3'd0, 3'd0, 3'd0, 6'd0, SRC_REG, 1'b0, 1'b0, 1'b0);
        cycle();
        push_all_zero("rst_init");
        flush();
        reset = 1'b1;

        // ADDI chain
        drive(OP_ADDI, 3'd1, 3'd0, 3'd0, 3'd0, 6'd10, SRC_IMM, 1'b1, 1'b0, 1'b0);
        push("addi1_alu", S_ALU, 16'd10); flush();
        cycle(); push("addi1_reg1", 1, 16'd10); flush();
        drive(OP_ADDI, 3'd2, 3'd0, 3'd0, 3'd0, 6'd9, SRC_IMM, 1'b1, 1'b0, 1'b0);
        cycle(); push("addi2_reg2", 2, 16'd9); flush();
        drive(OP_ADDI, 3'd7, 3'd1, 3'd0, 3'd0, 6'h3F, SRC_IMM, 1'b0, 1'b0, 1'b0);
        push("addi_neg_in2", S_IN2, 16'hFFFF);
        push("addi_neg_alu", S_ALU, 16'd9); flush();
        cycle();

        // R-type
        drive(OP_ADD, 3'd3, 3'd1, 3'd2, 3'd0, 6'd0, SRC_REG, 1'b1, 1'b0, 1'b0);
        push("add_in1", S_IN1, 16'd10);
        push("add_wb_pre", S_WB, 16'd19);
        push("add_reg3_pre", 3, 16'd0); flush();
        cycle(); push("add_reg3", 3, 16'd19); flush();
        drive(OP_SUB, 3'd7, 3'd1, 3'd2, 3'd0, 6'd0, SRC_REG, 1'b0, 1'b0, 1'b0);
        push("sub", S_ALU, 16'd1); flush();
        drive(OP_AND, 3'd7, 3'd1, 3'd2, 3'd0, 6'd0, SRC_REG, 1'b0, 1'b0, 1'b0);
        push("and", S_ALU, 16'd8); flush();
        drive(OP_SLT, 3'd7, 3'd2, 3'd1, 3'd0, 6'd0, SRC_REG, 1'b0, 1'b0, 1'b0);
        push("slt_true", S_ALU, 16'd1); flush();
        drive(OP_SLT, 3'd7, 3'd1, 3'd2, 3'd0, 6'd0, SRC_REG, 1'b0, 1'b0, 1'b0);
        push("slt_false", S_ALU, 16'd0); flush();
        drive(OP_SUB, 3'd7, 3'd2, 3'd1, 3'd0, 6'd0, SRC_REG, 1'b0, 1'b0, 1'b0);
        push("sub_wrap", S_ALU, 16'hFFFF); flush();
        drive(OP_OR, 3'd7, 3'd1, 3'd2, 3'd0, 6'd0, SRC_REG, 1'b0, 1'b0, 1'b0);
        push("or", S_ALU, 16'd11); flush();
        drive(OP_XOR, 3'd7, 3'd1, 3'd2, 3'd0, 6'd0, SRC_REG, 1'b0, 1'b0, 1'b0);
        push("xor", S_ALU, 16'd3); flush();
        drive(OP_NOT, 3'd7, 3'd1, 3'd2, 3'd0, 6'd0, SRC_REG, 1'b0, 1'b0, 1'b0);
        push("not", S_ALU, 16'hFFF5); flush();
        drive(4'b1101, 3'd7, 3'd1, 3'd2, 3'd0, 6'd0, SRC_REG, 1'b0, 1'b0, 1'b0);
        push("bad_op", S_ALU, 16'd0); flush();
        drive(OP_ADD, 3'd7, 3'd1, 3'd2, 3'd0, 6'd0, SRC_ZERO, 1'b0, 1'b0, 1'b0);
        push("src_zero_in2", S_IN2, 16'd0);
        push("src_zero_alu", S_ALU, 16'd10); flush();

        // Shifts
        drive(OP_SLL, 3'd7, 3'd1, 3'd0, 3'd3, 6'd0, SRC_SHAMT, 1'b0, 1'b0, 1'b0);
        push("sll", S_ALU, 16'd80); flush();
        drive(OP_ADDI, 3'd4, 3'd0, 3'd0, 3'd0, 6'd1, SRC_IMM, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(OP_SLL, 3'd4, 3'd4, 3'd0, 3'd0, 6'd15, SRC_IMM, 1'b1, 1'b0, 1'b0);
        cycle(); push("sll15_reg4", 4, 16'h8000); flush();
        drive(OP_SRA, 3'd7, 3'd4, 3'd0, 3'd1, 6'd0, SRC_SHAMT, 1'b0, 1'b0, 1'b0);
        push("sra", S_ALU, 16'hC000); flush();
        drive(OP_SRL, 3'd7, 3'd4, 3'd0, 3'd1, 6'd0, SRC_SHAMT, 1'b0, 1'b0, 1'b0);
        push("srl", S_ALU, 16'h4000); flush();

        // Store then load, address 10 wraps to 2
        drive(OP_SW, 3'd3, 3'd1, 3'd0, 3'd0, 6'd0, SRC_IMM, 1'b0, 1'b1, 1'b1);
        push("sw_wb_old", S_WB, 16'd0); flush();
        cycle(); push("sw_mem2", S_MEM + 2, 16'd19); flush();
        drive(OP_LW, 3'd5, 3'd1, 3'd0, 3'd0, 6'd0, SRC_IMM, 1'b1, 1'b1, 1'b0);
        push("lw_wb_pre", S_WB, 16'd19); flush();
        cycle(); push("lw_reg5", 5, 16'd19); flush();

        // Both strobes: mem gets old R3, R3 gets ALU result
        drive(OP_SW, 3'd3, 3'd1, 3'd0, 3'd0, 6'd1, SRC_IMM, 1'b1, 1'b0, 1'b1);
        push("both_wb", S_WB, 16'd11); flush();
        cycle();
        push("both_reg3", 3, 16'd11);
        push("both_mem3", S_MEM + 3, 16'd19); flush();

        // Register 0 write
        drive(OP_ADDI, 3'd0, 3'd0, 3'd0, 3'd0, 6'd5, SRC_IMM, 1'b1, 1'b0, 1'b0);
        push("r0_wb", S_WB, 16'd5); flush();
        cycle();
`ifdef R0_ZERO_EN
        push("r0_reg0", 0, 16'd0);
`else
        push("r0_reg0", 0, 16'd5);
`endif
        flush();

        // Random ops against the model
        for (int n = 0; n < 40; n++) begin
            drive(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            push("rnd_alu", S_ALU, m_alu());
            push("rnd_wb", S_WB, m_wb());
            flush();
            cycle();
            for (int i = 0; i < 8; i++) begin
                push($sformatf("rnd_reg%0d", i), i, m_rd(3'(i)));
                push($sformatf("rnd_mem%0d", i), S_MEM + i, mm[i]);
            end
            flush();
        end

        // Reset overrides concurrent writes
        drive(OP_ADDI, 3'd6, 3'd1, 3'd0, 3'd0, 6'd7, SRC_IMM, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        cycle();
        push_all_zero("rst_wr");
        flush();
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
